// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that turns bit-reversed FFT bins into natural order.
// Optional macro FFT_REORDER_LAST_CHECK_EN adds the sticky err_frame framing check on s_last.
`timescale 1ns/1ps
`default_nettype none

package fft_pkg;
  localparam int DATA_WIDTH = 16;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } complex_t;
endpackage

// +--------------------------------------------------------------------------+
// | fft_bitrev_reorder - bit-reversed to natural order reorder buffer        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fft_bitrev_reorder #(
  parameter int N_POINTS   = 16,
  parameter int DATA_WIDTH = fft_pkg::DATA_WIDTH,
  parameter int LOG2N      = $clog2(N_POINTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_last
`ifdef FFT_REORDER_LAST_CHECK_EN
  ,
  output logic                    err_frame
`endif
);

  localparam logic [LOG2N-1:0] c_LAST_IDX = LOG2N'(N_POINTS - 1);

  logic [2*DATA_WIDTH-1:0] mem_q [2][N_POINTS];

  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;

  logic             w_wr_fire;
  logic             w_rd_fire;
  logic [LOG2N-1:0] w_rd_addr;

  assign s_ready   = ~full_q[wr_bank_q];
  assign m_valid   = full_q[rd_bank_q];
  assign w_wr_fire = s_valid & s_ready;
  assign w_rd_fire = m_valid & m_ready;

  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
    assign w_rd_addr[gi] = rd_cnt_q[LOG2N-1-gi];
  end

  assign m_data = m_valid ? mem_q[rd_bank_q][w_rd_addr] : '0;
  assign m_last = m_valid & (rd_cnt_q == c_LAST_IDX);

  // Set and clear of full can land in the same cycle; they always hit different banks.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (w_wr_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_cnt_q == c_LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (w_rd_fire) begin
      rd_cnt_d = rd_cnt_q + LOG2N'(1);
      if (rd_cnt_q == c_LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      mem_q[wr_bank_q][wr_cnt_q] <= s_data;
    end
  end

`ifdef FFT_REORDER_LAST_CHECK_EN
  logic err_frame_q, err_frame_d;

  assign err_frame_d = err_frame_q | (w_wr_fire & (s_last != (wr_cnt_q == c_LAST_IDX)));
  assign err_frame   = err_frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame_q <= 1'b0;
    end else begin
      err_frame_q <= err_frame_d;
    end
  end
`else
  logic w_unused_s_last;
  assign w_unused_s_last = s_last;
`endif

endmodule

`default_nettype wire
